bank_cmd_stats_monitor: RTL and testbench
=========================================

BANK_CMD_STATS_MONITOR -- requirements
Module: bank_cmd_stats_monitor

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4: number of monitored banks (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: width of every counter (8..64).
REQ-003 SHALL derive localparam BANK_W = max(1, clog2(NUM_BANKS)).
REQ-004 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  input  1: command-bus sample is valid this cycle.
REQ-007 SHALL have ports cs, ras, cas, we  input  1 each: DRAM command pins, active-low encoding.
REQ-008 SHALL have port cmd_bank  input  BANK_W: target bank of the command.
REQ-009 SHALL have port clear  input  1: synchronous statistics clear pulse.
REQ-010 SHALL have port rd_valid  input  1: readout request.
REQ-011 SHALL have port rd_ready  output  1: readout request accepted when rd_valid and rd_ready.
REQ-012 SHALL have ports rd_bank  input  BANK_W and rd_type  input  3: counter selection.
REQ-013 SHALL have ports resp_valid  output  1 and resp_data  output  CNT_W: readout response.
REQ-014 SHALL have ports err_flag  output  1, err_count  output  CNT_W, bank_open  output  NUM_BANKS.

Function
REQ-015 SHALL decode only when cmd_valid=1 and cs=0 as {ras,cas,we}: 001 REF (type 0), 010 PRE (1), 011 ACT (2), 101 RD (3), 100 WR (4); all other encodings and cs=1 ignored.
REQ-016 SHALL keep one CNT_W counter per bank per type (5 x NUM_BANKS), updated at the edge sampling the command.
REQ-017 SHALL increment the REF counter of every bank on REF; other types increment only the cmd_bank counter.
REQ-018 SHALL saturate every counter, including err_count, at all-ones; no wrap-around.
REQ-019 SHALL track bank_open[b]: ACT sets, PRE clears, REF leaves unchanged.
REQ-020 SHALL flag a protocol error for: RD/WR to a closed bank; ACT to an open bank; REF while any bank is open; decoded command with cmd_bank >= NUM_BANKS.
REQ-021 SHALL still count and apply state effects of erroneous in-range commands; out-of-range cmd_bank only increments err_count.
REQ-022 SHALL increment err_count by 1 per erroneous command and set err_flag sticky until clear or reset.
REQ-023 SHALL, on clear=1, zero all type counters, err_count and err_flag at that edge; bank_open is preserved.
REQ-024 SHALL, on clear coincident with a command, apply the command's bank_open effect but not count it or flag it.
REQ-025 SHALL drive rd_ready=1 except in cycles with clear=1.
REQ-026 SHALL assert resp_valid for exactly one cycle, the cycle after acceptance, with resp_data = selected counter value before the accept edge's updates.
REQ-027 SHALL return resp_data=0 for rd_type 5..7 or rd_bank >= NUM_BANKS.
REQ-028 SHALL accept back-to-back reads, one response per cycle, in order.

Reset
REQ-029 SHALL, while reset_n=0, immediately force all counters, err_count, err_flag, bank_open and resp_valid to 0 and resp_data to 0.
REQ-030 SHALL drive rd_ready=1 from the first edge after reset_n deasserts; reset mid-readout drops the pending response.

Verification
REQ-031 Bank 1: ACT, RD, RD, WR, PRE; read types 2,3,4,1 of bank 1 -> 1, 2, 1, 1; err_count=0; bank_open=0.
REQ-032 RD to closed bank 0, then ACT, ACT bank 0 -> err_count=2, err_flag=1, ACT count bank 0 = 2, bank_open[0]=1.
REQ-033 REF with bank 2 open -> REF count=1 in all 4 banks, err_count=1.
REQ-034 CNT_W=8: 300 ACT/PRE pairs on bank 3 -> ACT and PRE counts read 255.
REQ-035 clear in same cycle as ACT bank 0 -> all counters 0, err_flag=0, bank_open[0]=1, rd_ready=0 that cycle.
REQ-036 reset_n low mid-stream -> all outputs 0 asynchronously; no resp_valid after release until a new accepted read.

Source files
------------

// File: rtl/bank_cmd_stats_monitor_if.sv
// Command-bus sample, readout handshake and status outputs of the bank command statistics monitor.
// The master drives commands and readout requests; the monitor is the slave.
interface bank_cmd_stats_monitor_if #(
   parameter int NUM_BANKS = 4,
   parameter int CNT_W     = 32
);
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic                 cmd_valid;
   logic                 cs;
   logic                 ras;
   logic                 cas;
   logic                 we;
   logic [BANK_W-1:0]    cmd_bank;
   logic                 clear;
   logic                 rd_valid;
   logic                 rd_ready;
   logic [BANK_W-1:0]    rd_bank;
   logic [2:0]           rd_type;
   logic                 resp_valid;
   logic [CNT_W-1:0]     resp_data;
   logic                 err_flag;
   logic [CNT_W-1:0]     err_count;
   logic [NUM_BANKS-1:0] bank_open;

   modport master (
      output cmd_valid, cs, ras, cas, we, cmd_bank, clear, rd_valid, rd_bank, rd_type,
      input  rd_ready, resp_valid, resp_data, err_flag, err_count, bank_open
   );

   modport slave (
      input  cmd_valid, cs, ras, cas, we, cmd_bank, clear, rd_valid, rd_bank, rd_type,
      output rd_ready, resp_valid, resp_data, err_flag, err_count, bank_open
   );
endinterface

// File: rtl/bank_cmd_stats_monitor.sv
// Per-bank DRAM command statistics: saturating counters per bank and command type,
// open-bank tracking, protocol-error detection and a one-cycle-latency counter readout.
module bank_cmd_stats_monitor #(
   parameter int NUM_BANKS = 4,
   parameter int CNT_W     = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   bank_cmd_stats_monitor_if.slave bus
);
   localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int NUM_TYPES = 5;

   typedef enum logic [2:0] {
      CMD_REF = 3'd0,
      CMD_PRE = 3'd1,
      CMD_ACT = 3'd2,
      CMD_RD  = 3'd3,
      CMD_WR  = 3'd4
   } cmd_type_e;

   logic [CNT_W-1:0]     cnt_q [NUM_BANKS][NUM_TYPES];
   logic [CNT_W-1:0]     err_count_q;
   logic                 err_flag_q;
   logic [NUM_BANKS-1:0] bank_open_q;
   logic [NUM_BANKS-1:0] bank_open_d;
   logic                 rd_ready_q;
   logic                 resp_valid_q;
   logic [CNT_W-1:0]     resp_data_q;

   cmd_type_e                           cmd_type;
   logic                                cmd_hit;
   logic                                cmd_in_range;
   logic                                tgt_open;
   logic                                cmd_err;
   logic [NUM_BANKS-1:0][NUM_TYPES-1:0] cnt_inc;
   logic [CNT_W-1:0]                    rd_sel;
   logic                                rd_ready;
   logic                                rd_accept;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
      cmd_hit  = 1'b0;
      cmd_type = CMD_REF;
      if (bus.cmd_valid && !bus.cs) begin
         cmd_hit = 1'b1;
         case ({bus.ras, bus.cas, bus.we})
            3'b001:  cmd_type = CMD_REF;
            3'b010:  cmd_type = CMD_PRE;
            3'b011:  cmd_type = CMD_ACT;
            3'b101:  cmd_type = CMD_RD;
            3'b100:  cmd_type = CMD_WR;
            default: cmd_hit  = 1'b0;
         endcase
      end
   end

   always_comb begin
      cmd_in_range = 1'b0;
      tgt_open     = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bus.cmd_bank == BANK_W'(b)) begin
            cmd_in_range = 1'b1;
            tgt_open     = bank_open_q[b];
         end
      end
   end

   // Out-of-range banks are always an error; in-range commands are judged against the open-bank state.
   always_comb begin
      cmd_err = 1'b0;
      if (cmd_hit) begin
         if (!cmd_in_range) begin
            cmd_err = 1'b1;
         end else begin
            case (cmd_type)
               CMD_REF:        cmd_err = |bank_open_q;
               CMD_ACT:        cmd_err = tgt_open;
               CMD_RD, CMD_WR: cmd_err = !tgt_open;
               default:        cmd_err = 1'b0;
            endcase
         end
      end
   end

   always_comb begin
      cnt_inc     = '0;
      bank_open_d = bank_open_q;
      if (cmd_hit && cmd_in_range) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (cmd_type == CMD_REF) begin
               cnt_inc[b][CMD_REF] = 1'b1;
            end else if (bus.cmd_bank == BANK_W'(b)) begin
               cnt_inc[b][cmd_type] = 1'b1;
               if (cmd_type == CMD_ACT) bank_open_d[b] = 1'b1;
               if (cmd_type == CMD_PRE) bank_open_d[b] = 1'b0;
            end
         end
      end
   end

   // Unselectable bank/type combinations fall through to zero.
   always_comb begin
      rd_sel = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int t = 0; t < NUM_TYPES; t++) begin
            if (bus.rd_bank == BANK_W'(b) && bus.rd_type == 3'(t)) rd_sel = cnt_q[b][t];
         end
      end
   end

   assign rd_ready  = rd_ready_q & ~bus.clear;
   assign rd_accept = bus.rd_valid & rd_ready;

   // NOTE: the counter array is reset, not left to power-up, because every counter must read zero while reset_n is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            for (int t = 0; t < NUM_TYPES; t++) cnt_q[b][t] <= '0;
         end
         err_count_q  <= '0;
         err_flag_q   <= 1'b0;
         bank_open_q  <= '0;
         rd_ready_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values, e.g. the readout sees counters before this edge's increments.
         for (int b = 0; b < NUM_BANKS; b++) begin
            for (int t = 0; t < NUM_TYPES; t++) begin
               if (bus.clear)         cnt_q[b][t] <= '0;
               else if (cnt_inc[b][t]) cnt_q[b][t] <= sat_inc(cnt_q[b][t]);
            end
         end
         if (bus.clear) begin
            err_count_q <= '0;
            err_flag_q  <= 1'b0;
         end else if (cmd_err) begin
            err_count_q <= sat_inc(err_count_q);
            err_flag_q  <= 1'b1;
         end
         bank_open_q  <= bank_open_d;
         rd_ready_q   <= 1'b1;
         resp_valid_q <= rd_accept;
         if (rd_accept) resp_data_q <= rd_sel;
      end
   end

   assign bus.rd_ready   = rd_ready;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.err_flag   = err_flag_q;
   assign bus.err_count  = err_count_q;
   assign bus.bank_open  = bank_open_q;
endmodule

// File: tb/tb_bank_cmd_stats_monitor.sv
// Bench for bank_cmd_stats_monitor: a 4-bank and a 3-bank instance (8-bit counters) share one stimulus
// stream and are compared every cycle against a behavioural model, plus directed literal scenarios.
module tb_bank_cmd_stats_monitor;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = 255;
   localparam int NU      = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_valid = 1'b0, cs = 1'b1, ras = 1'b1, cas = 1'b1, we = 1'b1;
   logic [1:0] cmd_bank = '0;
   logic       clear = 1'b0;
   logic       rd_valid = 1'b0;
   logic [1:0] rd_bank = '0;
   logic [2:0] rd_type = '0;

   int checks = 0;
   int errors = 0;

   bank_cmd_stats_monitor_if #(.NUM_BANKS(4), .CNT_W(CNT_W)) if0 ();
   bank_cmd_stats_monitor_if #(.NUM_BANKS(3), .CNT_W(CNT_W)) if1 ();

   assign if0.cmd_valid = cmd_valid;  assign if1.cmd_valid = cmd_valid;
   assign if0.cs        = cs;         assign if1.cs        = cs;
   assign if0.ras       = ras;        assign if1.ras       = ras;
   assign if0.cas       = cas;        assign if1.cas       = cas;
   assign if0.we        = we;         assign if1.we        = we;
   assign if0.cmd_bank  = cmd_bank;   assign if1.cmd_bank  = cmd_bank;
   assign if0.clear     = clear;      assign if1.clear     = clear;
   assign if0.rd_valid  = rd_valid;   assign if1.rd_valid  = rd_valid;
   assign if0.rd_bank   = rd_bank;    assign if1.rd_bank   = rd_bank;
   assign if0.rd_type   = rd_type;    assign if1.rd_type   = rd_type;

   bank_cmd_stats_monitor #(.NUM_BANKS(4), .CNT_W(CNT_W)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
   bank_cmd_stats_monitor #(.NUM_BANKS(3), .CNT_W(CNT_W)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

   initial forever #5 clk = ~clk;

   // Behavioural model: plain per-unit arrays of counts and open flags.
   int m_cnt  [NU][4][5];
   int m_errc [NU];
   bit m_errf [NU];
   bit m_open [NU][4];
   bit m_en   [NU];
   bit m_rv   [NU];
   int m_rd   [NU];

   function automatic int nb(input int u);
      return (u == 0) ? 4 : 3;
   endfunction

   function automatic int decode();
      if (!(cmd_valid && !cs)) return -1;
      case ({ras, cas, we})
         3'b001:  return 0;
         3'b010:  return 1;
         3'b011:  return 2;
         3'b101:  return 3;
         3'b100:  return 4;
         default: return -1;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < NU; u++) begin
         for (int b = 0; b < 4; b++) begin
            m_open[u][b] = 1'b0;
            for (int t = 0; t < 5; t++) m_cnt[u][b][t] = 0;
         end
         m_errc[u] = 0; m_errf[u] = 1'b0; m_en[u] = 1'b0; m_rv[u] = 1'b0; m_rd[u] = 0;
      end
   endtask

   task automatic model_step();
      int  t;
      bit  inr, err, any_open;
      if (!reset_n) return;
      t = decode();
      for (int u = 0; u < NU; u++) begin
         m_rv[u] = rd_valid && m_en[u] && !clear;
         if (m_rv[u]) m_rd[u] = (rd_type < 5 && int'(rd_bank) < nb(u)) ? m_cnt[u][rd_bank][rd_type] : 0;
         if (t >= 0) begin
            inr = int'(cmd_bank) < nb(u);
            any_open = 1'b0;
            for (int b = 0; b < nb(u); b++) any_open |= m_open[u][b];
            if (!inr)                 err = 1'b1;
            else if (t == 0)          err = any_open;
            else if (t == 2)          err = m_open[u][cmd_bank];
            else if (t == 3 || t == 4) err = !m_open[u][cmd_bank];
            else                      err = 1'b0;
            if (!clear) begin
               if (inr) begin
                  if (t == 0) begin
                     for (int b = 0; b < nb(u); b++)
                        if (m_cnt[u][b][0] < CNT_MAX) m_cnt[u][b][0]++;
                  end else if (m_cnt[u][cmd_bank][t] < CNT_MAX) begin
                     m_cnt[u][cmd_bank][t]++;
                  end
               end
               if (err) begin
                  if (m_errc[u] < CNT_MAX) m_errc[u]++;
                  m_errf[u] = 1'b1;
               end
            end
            if (inr && t == 2) m_open[u][cmd_bank] = 1'b1;
            if (inr && t == 1) m_open[u][cmd_bank] = 1'b0;
         end
         if (clear) begin
            for (int b = 0; b < 4; b++) for (int k = 0; k < 5; k++) m_cnt[u][b][k] = 0;
            m_errc[u] = 0;
            m_errf[u] = 1'b0;
         end
         m_en[u] = 1'b1;
      end
   endtask

   task automatic cmp_unit(input int u, input logic rdy, input logic rv, input logic [7:0] rd,
                           input logic ef, input logic [7:0] ec, input logic [3:0] bo);
      logic [3:0] bo_exp;
      bo_exp = '0;
      for (int b = 0; b < nb(u); b++) bo_exp[b] = m_open[u][b];
      check($sformatf("u%0d rd_ready", u), rdy, m_en[u] && !clear);
      check($sformatf("u%0d resp_valid", u), rv, m_rv[u]);
      if (m_rv[u]) check($sformatf("u%0d resp_data", u), rd, m_rd[u]);
      check($sformatf("u%0d err_flag", u), ef, m_errf[u]);
      check($sformatf("u%0d err_count", u), ec, m_errc[u]);
      check($sformatf("u%0d bank_open", u), bo, bo_exp);
   endtask

   always @(negedge clk) begin
      cmp_unit(0, if0.rd_ready, if0.resp_valid, if0.resp_data, if0.err_flag, if0.err_count, if0.bank_open);
      cmp_unit(1, if1.rd_ready, if1.resp_valid, if1.resp_data, if1.err_flag, if1.err_count, {1'b0, if1.bank_open});
   end

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_cmd();
      cmd_valid = 1'b0; cs = 1'b1; {ras, cas, we} = 3'b111; clear = 1'b0;
   endtask

   task automatic send(input int t, input int b);
      logic [2:0] e;
      case (t)
         0:       e = 3'b001;
         1:       e = 3'b010;
         2:       e = 3'b011;
         3:       e = 3'b101;
         default: e = 3'b100;
      endcase
      cmd_valid = 1'b1; cs = 1'b0; {ras, cas, we} = e; cmd_bank = 2'(b);
      cycle();
      idle_cmd();
   endtask

   task automatic read_lit(input string name, input int b, input int t, input int exp);
      rd_valid = 1'b1; rd_bank = 2'(b); rd_type = 3'(t);
      cycle();
      rd_valid = 1'b0;
      check({name, " valid"}, if0.resp_valid, 1'b1);
      check(name, if0.resp_data, exp);
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, " resp_valid"}, if0.resp_valid, 1'b0);
      check({name, " resp_data"}, if0.resp_data, 0);
      check({name, " err_flag"}, if0.err_flag, 1'b0);
      check({name, " err_count"}, if0.err_count, 0);
      check({name, " bank_open"}, if0.bank_open, 0);
      check({name, " rd_ready"}, if0.rd_ready, 1'b0);
   endtask

   task automatic apply_reset();
      idle_cmd(); rd_valid = 1'b0;
      reset_n = 1'b0;
      model_reset();
      #1;
      repeat (2) cycle();
      reset_n = 1'b1;
      cycle();
   endtask

   // Reset lands between edges; the pending response must be dropped.
   task automatic mid_reset();
      @(posedge clk);
      model_step();
      #3;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_zero_outputs("async reset");
      idle_cmd(); rd_valid = 1'b0;
      #1;
      repeat (2) cycle();
      reset_n = 1'b1;
      repeat (3) cycle();
      check("no resp after reset", if0.resp_valid, 1'b0);
   endtask

   initial begin
      model_reset();
      #1;
      check_zero_outputs("reset");
      repeat (2) cycle();
      reset_n = 1'b1;
      cycle();
      check("rd_ready after reset", if0.rd_ready, 1'b1);

      // Normal bank 1 sequence
      send(2, 1); send(3, 1); send(3, 1); send(4, 1); send(1, 1);
      read_lit("b1 ACT", 1, 2, 1);
      read_lit("b1 RD", 1, 3, 2);
      read_lit("b1 WR", 1, 4, 1);
      read_lit("b1 PRE", 1, 1, 1);
      read_lit("type 6 reads zero", 1, 6, 0);
      check("b1 err_count", if0.err_count, 0);
      check("b1 bank_open", if0.bank_open, 0);
      rd_valid = 1'b1; rd_bank = 2'd1; rd_type = 3'd3;
      cycle();
      check("b2b first", if0.resp_data, 2);
      rd_type = 3'd2;
      cycle();
      rd_valid = 1'b0;
      check("b2b second valid", if0.resp_valid, 1'b1);
      check("b2b second", if0.resp_data, 1);

      // RD to closed bank, then double ACT
      apply_reset();
      send(3, 0); send(2, 0); send(2, 0);
      check("err seq err_count", if0.err_count, 2);
      check("err seq err_flag", if0.err_flag, 1'b1);
      check("err seq bank_open", if0.bank_open, 4'b0001);
      read_lit("err seq ACT b0", 0, 2, 2);

      // REF with a bank open
      apply_reset();
      send(2, 2); send(0, 0);
      for (int b = 0; b < 4; b++) read_lit($sformatf("REF b%0d", b), b, 0, 1);
      check("REF err_count", if0.err_count, 1);

      // Saturation on 8-bit counters
      apply_reset();
      repeat (300) begin
         send(2, 3); send(1, 3);
      end
      read_lit("sat ACT b3", 3, 2, 255);
      read_lit("sat PRE b3", 3, 1, 255);
      check("sat err_count", if0.err_count, 0);

      // Clear coincident with ACT bank 0
      send(3, 1);
      check("pre-clear err_flag", if0.err_flag, 1'b1);
      cmd_valid = 1'b1; cs = 1'b0; {ras, cas, we} = 3'b011; cmd_bank = 2'd0; clear = 1'b1;
      #1;
      check("rd_ready low in clear", if0.rd_ready, 1'b0);
      cycle();
      idle_cmd();
      check("clear err_count", if0.err_count, 0);
      check("clear err_flag", if0.err_flag, 1'b0);
      check("clear bank_open", if0.bank_open, 4'b0001);
      read_lit("clear ACT b0", 0, 2, 0);
      read_lit("clear ACT b3", 3, 2, 0);

      // Reset mid-readout
      rd_valid = 1'b1; rd_bank = 2'd0; rd_type = 3'd2;
      cycle();
      check("pending resp_valid", if0.resp_valid, 1'b1);
      mid_reset();

      // Randomized stream checked by the model every cycle
      for (int i = 0; i < 4000; i++) begin
         cmd_valid = ($urandom_range(0, 9) < 7);
         cs        = ($urandom_range(0, 4) == 0);
         {ras, cas, we} = 3'($urandom_range(0, 7));
         cmd_bank  = 2'($urandom_range(0, 3));
         clear     = ($urandom_range(0, 49) == 0);
         rd_valid  = 1'($urandom_range(0, 1));
         rd_bank   = 2'($urandom_range(0, 3));
         rd_type   = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 499) == 0) mid_reset();
         else cycle();
      end

      idle_cmd(); rd_valid = 1'b0;
      repeat (2) cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
